// File: rtl/boot_control.sv
// Boot sequencing: tracks which ROM slots the HPS has downloaded, stretches the
// core reset after every reset source clears, and raises a one-shot OSD request.
module boot_control #(
  parameter int NUM_SLOTS          = 2,
  parameter int OSD_TIMEOUT_CYCLES = 99287000,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic                 status_reset,
  input  logic                 user_reset,
  output logic [NUM_SLOTS-1:0] slot_loaded,
  output logic                 all_loaded,
  output logic                 core_reset,
  output logic                 open_osd
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int CW = $clog2(OSD_TIMEOUT_CYCLES + 1);
  localparam logic [5:0] NS = 6'(NUM_SLOTS);

  typedef enum logic [1:0] {BOOT, ARMED, REQ, DONE} osd_state_e;

  logic                 dl_q;
  logic                 active_q, active_d;
  logic                 wr_seen_q, wr_seen_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [NUM_SLOTS-1:0] loaded_q, loaded_d;
  logic [HW-1:0]        hold_q, hold_d;
  osd_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 open_q, open_d;

  logic dl_start, dl_end, idx_ok, rst_src;
  logic unused_idx;

  assign unused_idx = ^ioctl_index[7:5];

  assign dl_start = ioctl_download & ~dl_q;
  assign dl_end   = ~ioctl_download & dl_q;
  assign idx_ok   = {1'b0, ioctl_index[4:0]} < NS;

  // Download tracking: an out-of-range index never sets active, so its end is a no-op.
  always_comb begin
    active_d  = active_q;
    wr_seen_d = wr_seen_q;
    slot_d    = slot_q;
    loaded_d  = loaded_q;
    if (dl_start) begin
      active_d  = idx_ok;
      wr_seen_d = ioctl_wr;
      if (idx_ok) begin
        slot_d                          = ioctl_index[SW-1:0];
        loaded_d[ioctl_index[SW-1:0]]   = 1'b0;
      end
    end else if (dl_end) begin
      if (active_q && wr_seen_q) loaded_d[slot_q] = 1'b1;
      active_d = 1'b0;
    end else if (active_q && ioctl_wr) begin
      wr_seen_d = 1'b1;
    end
  end

  assign slot_loaded = loaded_q;
  assign all_loaded  = &loaded_q;

  assign rst_src    = ~pll_locked | ioctl_download | ~all_loaded | status_reset | user_reset;
  assign hold_d     = rst_src ? HW'(RESET_HOLD_CYCLES)
                    : (hold_q != '0) ? hold_q - HW'(1) : hold_q;
  assign core_reset = rst_src | (hold_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    open_d  = 1'b0;
    unique case (state_q)
      BOOT:  if (status_reset) state_d = ARMED;
      ARMED: if (!status_reset) begin
               state_d = REQ;
               cnt_d   = CW'(OSD_TIMEOUT_CYCLES);
             end
      REQ: begin
        if (status_reset) begin
          state_d = ARMED;
        end else if (cnt_q == '0 || all_loaded) begin
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          open_d = ~all_loaded;
        end
      end
      DONE: ;
    endcase
  end

  assign open_osd = open_q;

  // dl_q reloads from the live input so a download spanning reset is never seen as started.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_q      <= ioctl_download;
      active_q  <= 1'b0;
      wr_seen_q <= 1'b0;
      slot_q    <= '0;
      loaded_q  <= '0;
      hold_q    <= HW'(RESET_HOLD_CYCLES);
      state_q   <= BOOT;
      cnt_q     <= '0;
      open_q    <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      active_q  <= active_d;
      wr_seen_q <= wr_seen_d;
      slot_q    <= slot_d;
      loaded_q  <= loaded_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      open_q    <= open_d;
    end
  end

endmodule

// File: tb/tb_boot_control.sv
// Directed bench for boot_control: a cycle table for loading/reset-hold behaviour,
// plus hand-written sequences for the OSD request FSM and reset-during-download.
module tb_boot_control;

  logic       clk_sys = 1'b0;
  logic       reset_n, pll_locked, ioctl_download, ioctl_wr, status_reset, user_reset;
  logic [7:0] ioctl_index;
  logic [1:0] slot_loaded;
  logic       all_loaded, core_reset, open_osd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  boot_control #(
    .NUM_SLOTS(2), .OSD_TIMEOUT_CYCLES(8), .RESET_HOLD_CYCLES(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pll_locked(pll_locked),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .status_reset(status_reset), .user_reset(user_reset),
    .slot_loaded(slot_loaded), .all_loaded(all_loaded),
    .core_reset(core_reset), .open_osd(open_osd)
  );

  typedef struct {
    logic       rst_n, pll, dl;
    logic [7:0] idx;
    logic       wr, sr, ur;
    logic [1:0] sl;
    logic       al, cr, oo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, p, d, input logic [7:0] ix, input logic w, s, u,
                     input logic [1:0] esl, input logic ea, ec, eo);
    vec_t v;
    v.rst_n = r; v.pll = p; v.dl = d; v.idx = ix; v.wr = w; v.sr = s; v.ur = u;
    v.sl = esl; v.al = ea; v.cr = ec; v.oo = eo;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n, input logic [1:0] esl, input logic ea, ec);
    for (int k = 0; k < n; k++) add(1, 1, 0, 8'd0, 0, 0, 0, esl, ea, ec, 0);
  endtask

  task automatic drv(input logic r, p, d, input logic [7:0] ix, input logic w, s, u);
    reset_n = r; pll_locked = p; ioctl_download = d; ioctl_index = ix;
    ioctl_wr = w; status_reset = s; user_reset = u;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 1, 0, 8'd0, 0, 0, 0);
    adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0);
  endtask

  task automatic enter_req();
    do_reset();
    status_reset = 1'b1; adv();
    status_reset = 1'b0; adv();
  endtask

  initial begin
    int cnt, first;

    // Each row: inputs for one cycle, outputs expected mid-cycle (before the edge).
    add(0, 1, 0, 8'd0, 0, 0, 0, 2'b00, 0, 1, 0);
    add(1, 1, 1, 8'd0, 0, 0, 0, 2'b00, 0, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 1, 8'd0, 1, 0, 0, 2'b00, 0, 1, 0);
    add(1, 1, 0, 8'd0, 0, 0, 0, 2'b00, 0, 1, 0);
    add(1, 1, 1, 8'd1, 0, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 1, 8'd1, 1, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 0, 8'd1, 0, 0, 0, 2'b01, 0, 1, 0);
    idle(4, 2'b11, 1, 1);
    idle(1, 2'b11, 1, 0);
    // zero-write download of slot 1, then an out-of-range index
    add(1, 1, 1, 8'd1, 0, 0, 0, 2'b11, 1, 1, 0);
    add(1, 1, 0, 8'd1, 0, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 1, 8'd5, 1, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 1, 8'd5, 1, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 0, 8'd5, 0, 0, 0, 2'b01, 0, 1, 0);
    idle(1, 2'b01, 0, 1);
    add(1, 1, 1, 8'd1, 1, 0, 0, 2'b01, 0, 1, 0);
    add(1, 1, 0, 8'd1, 0, 0, 0, 2'b01, 0, 1, 0);
    idle(4, 2'b11, 1, 1);
    idle(1, 2'b11, 1, 0);
    // user_reset pulse: 1 + 4 cycles
    add(1, 1, 0, 8'd0, 0, 0, 1, 2'b11, 1, 1, 0);
    idle(4, 2'b11, 1, 1);
    idle(1, 2'b11, 1, 0);
    // second pulse two cycles into the hold restarts it
    add(1, 1, 0, 8'd0, 0, 0, 1, 2'b11, 1, 1, 0);
    idle(2, 2'b11, 1, 1);
    add(1, 1, 0, 8'd0, 0, 0, 1, 2'b11, 1, 1, 0);
    idle(4, 2'b11, 1, 1);
    idle(1, 2'b11, 1, 0);
    // PLL drop
    add(1, 0, 0, 8'd0, 0, 0, 0, 2'b11, 1, 1, 0);
    idle(4, 2'b11, 1, 1);
    idle(1, 2'b11, 1, 0);

    drv(0, 1, 0, 8'd0, 0, 0, 0);
    adv(); adv();
    foreach (tbl[i]) begin
      drv(tbl[i].rst_n, tbl[i].pll, tbl[i].dl, tbl[i].idx, tbl[i].wr, tbl[i].sr, tbl[i].ur);
      @(negedge clk_sys);
      chk($sformatf("row%0d slot_loaded", i), 32'(slot_loaded), 32'(tbl[i].sl));
      chk($sformatf("row%0d all_loaded", i),  32'(all_loaded),  32'(tbl[i].al));
      chk($sformatf("row%0d core_reset", i),  32'(core_reset),  32'(tbl[i].cr));
      chk($sformatf("row%0d open_osd", i),    32'(open_osd),    32'(tbl[i].oo));
      adv();
    end

    // No ROM: open_osd high for exactly the timeout, then DONE ignores re-arming
    enter_req();
    cnt = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (open_osd === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      adv();
    end
    chk("noRom open cycles", 32'(cnt), 32'd8);
    chk("noRom open first", 32'(first), 32'd1);
    chk("noRom open end", 32'(open_osd), 32'd0);
    status_reset = 1'b1; adv();
    status_reset = 1'b0; adv();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (open_osd !== 1'b0) cnt++;
      adv();
    end
    chk("done terminal", 32'(cnt), 32'd0);

    // Both slots load three cycles into the request window
    enter_req();
    adv(); adv(); adv();
    drv(1, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0); adv();
    drv(1, 1, 1, 8'd1, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd1, 0, 0, 0);
    @(negedge clk_sys);
    chk("req load al before", 32'(all_loaded), 32'd0);
    adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0);
    @(negedge clk_sys);
    chk("req load al rise", 32'(all_loaded), 32'd1);
    chk("req load open still", 32'(open_osd), 32'd1);
    adv();
    @(negedge clk_sys);
    chk("req load open fall", 32'(open_osd), 32'd0);
    adv();

    // status_reset during REQ re-arms and the window reloads in full
    enter_req();
    adv(); adv(); adv();
    status_reset = 1'b1;
    @(negedge clk_sys);
    chk("rearm open before", 32'(open_osd), 32'd1);
    adv();
    status_reset = 1'b0;
    @(negedge clk_sys);
    chk("rearm open forced 0", 32'(open_osd), 32'd0);
    adv();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (open_osd === 1'b1) cnt++;
      adv();
    end
    chk("rearm open cycles", 32'(cnt), 32'd8);

    // Download end coincides with status_reset: both take effect
    do_reset();
    drv(1, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd0, 0, 1, 0); adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0);
    @(negedge clk_sys);
    chk("coincide slot", 32'(slot_loaded), 32'd1);
    adv(); adv();
    @(negedge clk_sys);
    chk("coincide fsm req", 32'(open_osd), 32'd1);
    adv();

    // reset_n mid-download discards it
    do_reset();
    drv(1, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0); adv();
    drv(1, 1, 1, 8'd1, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd1, 0, 0, 0); adv();
    @(negedge clk_sys);
    chk("midrst preload", 32'(slot_loaded), 32'd3);
    drv(1, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(0, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(1, 1, 1, 8'd0, 1, 0, 0);
    @(negedge clk_sys);
    chk("midrst slot", 32'(slot_loaded), 32'd0);
    chk("midrst all", 32'(all_loaded), 32'd0);
    chk("midrst core_reset", 32'(core_reset), 32'd1);
    chk("midrst open", 32'(open_osd), 32'd0);
    adv();
    drv(1, 1, 1, 8'd0, 1, 0, 0); adv();
    drv(1, 1, 0, 8'd0, 0, 0, 0); adv();
    @(negedge clk_sys);
    chk("midrst after end", 32'(slot_loaded), 32'd0);
    adv();
    @(negedge clk_sys);
    chk("midrst settled", 32'(slot_loaded), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
